// File: rtl/spart_tx.sv
// SPART transmitter: holding register plus shift register serialising 8N1 frames
// on the 16x oversample tick. Define SPART_TX_PARITY_EN to insert an even-parity bit.
module spart_tx #(
    parameter int OSR    = 16,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              brg_en,
    input  logic              load,
    input  logic [DATA_W-1:0] tx_data,
    output logic              txd,
    output logic              tbr,
    output logic              busy
);

    localparam int TW = (OSR > 1) ? $clog2(OSR) : 1;
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

`ifdef SPART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t            state_q, state_d;
    logic [TW-1:0]     tick_q, tick_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              tbr_q, tbr_d;
    logic              txd_q, txd_d;
    logic              busy_q, busy_d;
`ifdef SPART_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    logic bit_end;
    logic transfer;

    assign bit_end = brg_en && (tick_q == TW'(OSR - 1));

    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        bit_d    = bit_q;
        hold_d   = hold_q;
        shift_d  = shift_q;
        tbr_d    = tbr_q;
        transfer = 1'b0;
`ifdef SPART_TX_PARITY_EN
        parity_d = parity_q;
`endif

        // A load while the holding register is full is silently dropped.
        if (load && tbr_q) begin
            hold_d = tx_data;
            tbr_d  = 1'b0;
        end

        if (state_q != IDLE && brg_en) begin
            tick_d = bit_end ? '0 : tick_q + TW'(1);
        end

        case (state_q)
            IDLE: begin
                if (!tbr_q) begin
                    state_d  = START;
                    transfer = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BW'(DATA_W - 1)) begin
`ifdef SPART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
`ifdef SPART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    // Queued byte starts immediately, no idle gap between frames.
                    if (!tbr_q) begin
                        state_d  = START;
                        transfer = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (transfer) begin
            shift_d = hold_q;
            tbr_d   = 1'b1;
            tick_d  = '0;
`ifdef SPART_TX_PARITY_EN
            parity_d = ^hold_q;
`endif
        end
    end

    always_comb begin
        txd_d  = 1'b1;
        busy_d = (state_d != IDLE);
        case (state_d)
            IDLE:    txd_d = 1'b1;
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
`ifdef SPART_TX_PARITY_EN
            PARITY:  txd_d = parity_d;
`endif
            STOP:    txd_d = 1'b1;
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            tick_q   <= '0;
            bit_q    <= '0;
            hold_q   <= '0;
            shift_q  <= '0;
            tbr_q    <= 1'b1;
            txd_q    <= 1'b1;
            busy_q   <= 1'b0;
`ifdef SPART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            bit_q    <= bit_d;
            hold_q   <= hold_d;
            shift_q  <= shift_d;
            tbr_q    <= tbr_d;
            txd_q    <= txd_d;
            busy_q   <= busy_d;
`ifdef SPART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign txd  = txd_q;
    assign tbr  = tbr_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_spart_tx.sv
// Bench for spart_tx: decodes txd at bit centres and compares whole frames against
// frames built from the accepted bytes; brg_en pulses every 4 clk.
module tb_spart_tx;

    localparam int OSR     = 16;
    localparam int DW      = 8;
    localparam int BIT_CLK = OSR * 4;
`ifdef SPART_TX_PARITY_EN
    localparam int NB = DW + 3;
`else
    localparam int NB = DW + 2;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          brg_en = 1'b0;
    logic          load = 1'b0;
    logic [DW-1:0] tx_data = '0;
    logic          txd, tbr, busy;

    int n_cmp = 0;
    int n_err = 0;

    spart_tx #(.OSR(OSR), .DATA_W(DW)) dut (
        .clk    (clk),
        .rst    (rst),
        .brg_en (brg_en),
        .load   (load),
        .tx_data(tx_data),
        .txd    (txd),
        .tbr    (tbr),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    initial begin
        int phase;
        phase = 0;
        forever begin
            @(posedge clk);
            #1;
            brg_en = (phase == 3);
            phase  = (phase + 1) % 4;
        end
    end

    // Line monitor: a falling edge opens a frame, each bit is sampled at its centre.
    logic [NB-1:0] rx_q[$];
    int            fall_q[$];
    logic [NB-1:0] mon_bits;
    bit            mon_act = 1'b0;
    int            mon_cnt = 0;
    int            cyc_no = 0;
    logic          txd_prev = 1'b1;

    always @(negedge clk) begin
        cyc_no++;
        if (!rst) begin
            mon_act  = 1'b0;
            txd_prev = 1'b1;
        end else begin
            if (mon_act) begin
                mon_cnt++;
                if (mon_cnt % BIT_CLK == BIT_CLK / 2) begin
                    mon_bits[mon_cnt / BIT_CLK] = txd;
                    if (mon_cnt / BIT_CLK == NB - 1) begin
                        rx_q.push_back(mon_bits);
                        mon_act = 1'b0;
                    end
                end
            end else if (txd_prev === 1'b1 && txd === 1'b0) begin
                mon_act  = 1'b1;
                mon_cnt  = 0;
                mon_bits = '1;
                fall_q.push_back(cyc_no);
            end
            txd_prev = txd;
        end
    end

    logic [DW-1:0] exp_q[$];

    function automatic logic [NB-1:0] frame_of(input logic [DW-1:0] b);
        logic [NB-1:0] f;
        int ones;
        f    = '1;
        f[0] = 1'b0;
        ones = 0;
        for (int i = 0; i < DW; i++) begin
            f[1 + i] = b[i];
            if (b[i]) ones++;
        end
`ifdef SPART_TX_PARITY_EN
        f[DW + 1] = (ones % 2 == 1);
`endif
        f[NB - 1] = 1'b1;
        return f;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [DW-1:0] b);
        load    = 1'b1;
        tx_data = b;
        step(1);
        load    = 1'b0;
        $display("load 0x%02h tbr_after=%0b", b, tbr);
    endtask

    task automatic wait_rx(input int n);
        int t;
        t = 0;
        while (rx_q.size() < n && t < n * NB * BIT_CLK + 400) begin
            step(1);
            t++;
        end
        check("rx_timeout", (rx_q.size() >= n) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic compare_rx();
        logic [NB-1:0] got, want;
        logic [DW-1:0] b;
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            b    = exp_q.pop_front();
            got  = rx_q.pop_front();
            want = frame_of(b);
            $display("frame byte=0x%02h got=%b want=%b", b, got, want);
            check("frame", 32'(got), 32'(want));
        end
        check("missing_frames", exp_q.size(), 0);
        check("extra_frames", rx_q.size(), 0);
        exp_q.delete();
        rx_q.delete();
    endtask

    initial begin
        logic [DW-1:0] b1, b2, b3;
        int gap;

        // Power-on reset values
        step(3);
        check("rst_txd", txd, 1);
        check("rst_tbr", tbr, 1);
        check("rst_busy", busy, 0);
        rst = 1'b1;
        step(3);

        // Reset mid-operation, with a byte queued behind the active frame
        b1 = DW'($urandom);
        send(b1);
        step(1);
        send(8'h3C);
        step(20);
        check("pre_rst_txd", txd, 0);
        check("pre_rst_tbr", tbr, 0);
        rst = 1'b0;
        #1;
        check("async_rst_txd", txd, 1);
        check("async_rst_tbr", tbr, 1);
        check("async_rst_busy", busy, 0);
        for (int i = 0; i < 8; i++) begin
            step(1);
            check("hold_rst_txd", txd, 1);
            check("hold_rst_busy", busy, 0);
        end
        rst = 1'b1;
        step(200);
        check("post_rst_busy", busy, 0);
        check("post_rst_txd", txd, 1);
        check("post_rst_tbr", tbr, 1);
        check("queued_discarded", rx_q.size(), 0);
        rx_q.delete();
        fall_q.delete();

        // Single byte 0xA5
        send(8'hA5);
        check("load_tbr0", tbr, 0);
        check("load_busy0", busy, 0);
        step(1);
        check("xfer_tbr1", tbr, 1);
        check("xfer_busy1", busy, 1);
        check("xfer_txd0", txd, 0);
        exp_q.push_back(8'hA5);
        wait_rx(1);
        compare_rx();
        step(60);
        check("single_idle_busy", busy, 0);
        check("single_idle_txd", txd, 1);

        // Back-to-back: zero idle gap, busy held throughout
        fall_q.delete();
        send(8'h55);
        step(1);
        check("b2b_tbr", tbr, 1);
        send(8'h0F);
        check("b2b_tbr_full", tbr, 0);
        exp_q.push_back(8'h55);
        exp_q.push_back(8'h0F);
        begin
            int t;
            t = 0;
            while (rx_q.size() < 2 && t < 2 * NB * BIT_CLK + 400) begin
                step(1);
                t++;
                check("b2b_busy", busy, 1);
            end
        end
        check("b2b_falls", fall_q.size(), 2);
        if (fall_q.size() >= 2) begin
            gap = fall_q[1] - fall_q[0];
            $display("b2b frame spacing %0d clk", gap);
            check("b2b_gap", (gap >= (NB - 1) * BIT_CLK + BIT_CLK - 3 &&
                              gap <= NB * BIT_CLK) ? 32'd1 : 32'd0, 32'd1);
        end
        compare_rx();
        step(60);
        check("b2b_idle_busy", busy, 0);

        // Overflow: third byte dropped while holding register full
        send(8'h11);
        step(1);
        send(8'h22);
        check("ovf_tbr_after_22", tbr, 0);
        step(5);
        send(8'h33);
        check("ovf_tbr_after_33", tbr, 0);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        wait_rx(2);
        compare_rx();
        step(60);
        check("ovf_idle_busy", busy, 0);

        // Reset during data bit 3 of 0xFF, then a clean 0x81 frame
        send(8'hFF);
        step(291);
        check("mid_busy", busy, 1);
        rst = 1'b0;
        #1;
        check("mid_rst_txd", txd, 1);
        check("mid_rst_busy", busy, 0);
        step(4);
        rst = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step(1);
            check("no_resume_txd", txd, 1);
        end
        check("no_partial_frame", rx_q.size(), 0);
        rx_q.delete();
        send(8'h81);
        exp_q.push_back(8'h81);
        wait_rx(1);
        compare_rx();
        step(60);

        // Parity reference bytes
        send(8'h07);
        exp_q.push_back(8'h07);
        wait_rx(1);
        compare_rx();
        step(60);
        send(8'h03);
        exp_q.push_back(8'h03);
        wait_rx(1);
        compare_rx();
        step(60);

        // Randomised pairs with a dropped third load
        for (int k = 0; k < 6; k++) begin
            b1 = DW'($urandom);
            b2 = DW'($urandom);
            b3 = DW'($urandom);
            send(b1);
            check("rnd_tbr0", tbr, 0);
            step(1);
            check("rnd_tbr1", tbr, 1);
            step($urandom_range(0, 40));
            send(b2);
            check("rnd_tbr_q", tbr, 0);
            step($urandom_range(1, 300));
            send(b3);
            check("rnd_drop_tbr", tbr, 0);
            exp_q.push_back(b1);
            exp_q.push_back(b2);
            wait_rx(2);
            compare_rx();
            step(60);
            check("rnd_idle_busy", busy, 0);
            check("rnd_idle_txd", txd, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
